// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the byte-wide instruction fetch
// Rev 1.0
// ============================================================================
package fetch_pkg;

   localparam int          BYTES_PER_WORD   = 4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   typedef enum logic [0:0] {
      ISSUE = 1'b0,
      HOLD  = 1'b1
   } issue_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : DEPTH-entry word FIFO of fetch_entry_t, flush beats push
// Rev 1.0
// ============================================================================
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  fetch_entry_t                 i_data,
   input  logic                         i_pop,
   input  logic                         i_flush,
   output fetch_entry_t                 o_head,
   output logic [$clog2(DEPTH+1)-1:0]   o_count,
   output logic                         o_empty,
   output logic                         o_full
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);

   fetch_entry_t     r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == c_depth);
   assign o_count   = r_count;
   assign o_head    = r_mem[r_rd_ptr];
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is only accepted when the head leaves in the same cycle.
   assign w_do_push = i_push && (!o_full || w_do_pop);

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push && !rst && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/ifetch_byte_buffer.sv
`default_nettype none
// ============================================================================
// ifetch_byte_buffer : assembles big-endian words from a byte memory, buffers them
// Rev 1.0
// ============================================================================
module ifetch_byte_buffer
   import fetch_pkg::*;
#(
   parameter int          ADDR_W   = 5,
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [7:0]        mem_rdata,
   input  logic              redirect,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [31:0]       out_pc
);

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] c_depth = (CNT_W + 1)'(DEPTH);

   issue_state_t r_state;
   issue_state_t w_state_nxt;
   logic [31:0]  r_fetch_pc;
   logic [1:0]   r_byte_idx;
   logic         r_squash;
   logic         r_rd_valid;
   logic         r_rd_last;
   logic [31:0]  r_rd_pc;
   logic [23:0]  r_shift;

   logic             w_issue;
   logic             w_can_issue;
   logic             w_free;
   logic             w_capture;
   logic             w_push;
   logic [CNT_W-1:0] w_count;
   logic [CNT_W:0]   w_used;
   logic             w_empty;
   logic             w_full;
   logic [31:0]      w_redirect_pc;
   fetch_entry_t     w_push_data;
   fetch_entry_t     w_head;

   // The word whose last byte is still returning already owns a slot.
   assign w_used      = {1'b0, w_count} + {{CNT_W{1'b0}}, r_rd_last};
   assign w_free      = !w_full && (w_used < c_depth);
   assign w_can_issue = (r_byte_idx != 2'd0) || w_free;

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         ISSUE: begin
            if (w_can_issue) w_issue = 1'b1;
            else             w_state_nxt = HOLD;
         end
         HOLD: begin
            if (w_can_issue) begin
               w_issue     = 1'b1;
               w_state_nxt = ISSUE;
            end
         end
         default: w_state_nxt = ISSUE;
      endcase
      if (reset || redirect) begin
         w_issue     = 1'b0;
         w_state_nxt = ISSUE;
      end
   end

   assign mem_en        = w_issue;
   assign mem_addr      = r_fetch_pc[ADDR_W-1:0] + ADDR_W'(r_byte_idx);
   assign w_redirect_pc = redirect_pc & ~32'h3;
   assign w_capture     = r_rd_valid && !r_squash;
   assign w_push        = w_capture && r_rd_last && !redirect;
   assign w_push_data   = '{pc: r_rd_pc, instr: {r_shift, mem_rdata}};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ISSUE;
         r_fetch_pc <= RESET_PC;
         r_byte_idx <= 2'd0;
         r_squash   <= 1'b0;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_rd_pc    <= 32'd0;
         r_shift    <= 24'd0;
      end else if (redirect) begin
         r_state    <= ISSUE;
         r_fetch_pc <= w_redirect_pc;
         r_byte_idx <= 2'd0;
         r_squash   <= 1'b1;
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         r_shift    <= 24'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_squash   <= 1'b0;
         r_rd_valid <= w_issue;
         r_rd_last  <= w_issue && (r_byte_idx == 2'd3);
         if (w_issue) begin
            r_rd_pc    <= r_fetch_pc;
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) r_fetch_pc <= r_fetch_pc + 32'd4;
         end
         if (w_capture) r_shift <= {r_shift[15:0], mem_rdata};
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (out_valid && out_ready),
      .i_flush (redirect),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign out_valid = !reset && !w_empty;
   assign out_instr = reset ? 32'd0 : w_head.instr;
   assign out_pc    = reset ? 32'd0 : w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_byte_buffer.sv
`default_nettype none
// Bench for ifetch_byte_buffer: byte memory model, scoreboard of expected words,
// table of redirect targets plus hand-written reset/redirect corner sequences.
module tb_ifetch_byte_buffer;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        reset, redirect, out_ready, mem_en, out_valid;
   logic [4:0]  mem_addr;
   logic [7:0]  mem_rdata;
   logic [31:0] redirect_pc, out_instr, out_pc;

   logic        wr_ready, wr_mem_en, wr_out_valid;
   logic [4:0]  wr_mem_addr;
   logic [7:0]  wr_mem_rdata;
   logic [31:0] wr_out_instr, wr_out_pc;

   logic [7:0]   mem [32];
   fetch_entry_t exp_q [$];
   int           errors = 0;
   int           checks = 0;
   int           hs_count = 0;

   typedef struct {
      logic [31:0] target;
      logic [31:0] exp_pc;
      logic [31:0] exp_instr;
   } vec_t;
   vec_t vecs [4];

   always #5 clk = ~clk;

   ifetch_byte_buffer #(.ADDR_W(5), .DEPTH(2), .RESET_PC(32'h0000_0000)) u_dut (
      .clk(clk), .reset(reset), .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .redirect(redirect), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
   );

   ifetch_byte_buffer #(.ADDR_W(5), .DEPTH(2), .RESET_PC(32'h0000_001C)) u_wrap (
      .clk(clk), .reset(reset), .mem_en(wr_mem_en), .mem_addr(wr_mem_addr),
      .mem_rdata(wr_mem_rdata), .redirect(1'b0), .redirect_pc(32'd0),
      .out_valid(wr_out_valid), .out_ready(wr_ready), .out_instr(wr_out_instr),
      .out_pc(wr_out_pc)
   );

   // Synchronous byte memory; unrequested cycles return a poison byte.
   always @(posedge clk) begin
      mem_rdata    <= mem_en    ? mem[mem_addr]    : 8'hEE;
      wr_mem_rdata <= wr_mem_en ? mem[wr_mem_addr] : 8'hEE;
   end

   function automatic logic [31:0] word_at(input logic [31:0] pc);
      logic [4:0] a;
      a = pc[4:0];
      return {mem[a], mem[a + 5'd1], mem[a + 5'd2], mem[a + 5'd3]};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         hs_count++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected: got pc %0h instr %0h expected no word", out_pc, out_instr);
         end else begin
            fetch_entry_t e;
            e = exp_q.pop_front();
            check("sb_pc", out_pc, e.pc);
            check("sb_instr", out_instr, e.instr);
         end
      end
   end

   task automatic cycle_start();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect = 1'b0; out_ready = 1'b0; wr_ready = 1'b0;
      @(negedge clk);
      check("rst_mem_en", mem_en, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_instr", out_instr, 0);
      check("rst_out_pc", out_pc, 0);
      cycle_start();
      cycle_start();
      reset = 1'b0;
      exp_q.delete();
   endtask

   // Runs cycles R..R+5 with out_ready high, expecting word 0 at R+5.
   task automatic check_first_word();
      fetch_entry_t e;
      e.pc = 32'd0; e.instr = 32'h2008_0005;
      exp_q.push_back(e);
      out_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("fw_mem_en", mem_en, 1);
         check("fw_addr", mem_addr, k);
         check("fw_wrap_addr", wr_mem_addr, (28 + k) % 32);
         check("fw_valid_timing", out_valid, k == 5);
         cycle_start();
      end
      out_ready = 1'b0;
      check("fw_sb_drained", exp_q.size(), 0);
   endtask

   task automatic redirect_and_check(input logic [31:0] target, input logic [31:0] exp_pc,
                                     input logic [31:0] exp_instr, input logic rdy_in_redirect);
      fetch_entry_t e;
      logic [4:0]   a;
      e.pc = exp_pc; e.instr = exp_instr;
      redirect = 1'b1; redirect_pc = target; out_ready = rdy_in_redirect;
      exp_q.push_back(e);
      @(negedge clk);
      check("rd_mem_en_low", mem_en, 0);
      cycle_start();
      redirect = 1'b0; out_ready = 1'b1;
      a = exp_pc[4:0];
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (k <= 4) begin
            check("rd_addr", mem_addr, a);
            a = a + 5'd1;
         end
         check("rd_valid_timing", out_valid, k == 6);
         cycle_start();
      end
      out_ready = 1'b0;
      check("rd_sb_drained", exp_q.size(), 0);
   endtask

   task automatic wait_drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         cycle_start();
         n++;
      end
      out_ready = 1'b0;
      check("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

   initial begin
      int n_en;
      int first_idle;
      int hs0;
      fetch_entry_t e;

      mem[0] = 8'h20; mem[1] = 8'h08; mem[2] = 8'h00; mem[3] = 8'h05;
      for (int i = 4; i < 32; i++) mem[i] = 8'(i * 29 + 65);
      vecs[0] = '{target: 32'h0000_0013, exp_pc: 32'h0000_0010, exp_instr: word_at(32'h10)};
      vecs[1] = '{target: 32'h0000_001E, exp_pc: 32'h0000_001C, exp_instr: word_at(32'h1C)};
      vecs[2] = '{target: 32'hFFFF_FFFD, exp_pc: 32'hFFFF_FFFC, exp_instr: word_at(32'h1C)};
      vecs[3] = '{target: 32'h0000_0041, exp_pc: 32'h0000_0040, exp_instr: 32'h2008_0005};

      reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; out_ready = 1'b0; wr_ready = 1'b0;

      // First word latency, address stream, and wrap DUT starting at 0x1C.
      do_reset();
      check_first_word();
      repeat (5) cycle_start();
      @(negedge clk);
      check("wrap_valid", wr_out_valid, 1);
      check("wrap_pc0", wr_out_pc, 32'h1C);
      check("wrap_instr0", wr_out_instr, word_at(32'h1C));
      cycle_start();
      wr_ready = 1'b1;
      cycle_start();
      wr_ready = 1'b0;
      @(negedge clk);
      check("wrap_pc1", wr_out_pc, 32'h20);
      check("wrap_instr1", wr_out_instr, 32'h2008_0005);
      cycle_start();

      // Backpressure: only two words fetched, then in-order drain.
      do_reset();
      n_en = 0; first_idle = -1;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (mem_en) n_en++;
         else if (first_idle < 0) first_idle = k;
         cycle_start();
      end
      check("bp_bytes_issued", n_en, 8);
      check("bp_first_idle", first_idle, 8);
      for (int i = 0; i < 3; i++) begin
         e.pc = 32'(i * 4); e.instr = word_at(32'(i * 4));
         exp_q.push_back(e);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_valid0", out_valid, 1);
      cycle_start();
      @(negedge clk);
      check("bp_valid1_no_gap", out_valid, 1);
      cycle_start();
      wait_drain(20);

      // Redirect while byte 2 of the pc-4 word is in flight.
      do_reset();
      e.pc = 32'd0; e.instr = 32'h2008_0005;
      exp_q.push_back(e);
      out_ready = 1'b1;
      repeat (6) cycle_start();
      @(negedge clk);
      check("mid_addr_byte2", mem_addr, 6);
      cycle_start();
      redirect_and_check(32'h13, 32'h10, word_at(32'h10), 1'b1);

      // Table of redirect targets at varying fetch phases.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         repeat (3 + 2 * i) cycle_start();
         redirect_and_check(vecs[i].target, vecs[i].exp_pc, vecs[i].exp_instr, 1'b0);
      end

      // Back-to-back redirects: the second target wins.
      redirect = 1'b1; redirect_pc = 32'h08;
      @(negedge clk);
      check("b2b_mem_en_low", mem_en, 0);
      cycle_start();
      redirect_and_check(32'h15, 32'h14, word_at(32'h14), 1'b0);

      // Reset after two bytes of a word: no stale bytes afterwards.
      do_reset();
      out_ready = 1'b1;
      repeat (2) cycle_start();
      do_reset();
      check_first_word();

      // Handshake coincides with redirect while two entries are held.
      do_reset();
      repeat (12) cycle_start();
      @(negedge clk);
      check("hr_valid_before", out_valid, 1);
      cycle_start();
      e.pc = 32'd0; e.instr = 32'h2008_0005;
      exp_q.push_back(e);
      hs0 = hs_count;
      redirect_and_check(32'h0C, 32'h0C, word_at(32'h0C), 1'b1);
      check("hr_handshakes", hs_count - hs0, 2);

      check("final_sb_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
